// File: rtl/mac_tx_pkt_gen.sv
// mac_tx_pkt_gen: parametrised frame generator for the MAC user transmit interface (clk_user domain).
// Optional build macro PKT_GEN_SEQ_EN: the first 4 payload bytes of each frame carry the run frame index.
module mac_tx_pkt_gen #(
  parameter int DATA_W  = 32,
  parameter int BE_W    = $clog2(DATA_W/8),
  parameter int LEN_W   = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1514,
  parameter int IFG_CYC = 4
) (
  input  logic              clk_user,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       frame_cnt,
  input  logic [1:0]        len_mode,
  input  logic [LEN_W-1:0]  fix_len,
  input  logic              pat_sel,
  input  logic              tx_mac_wa,
  output logic              tx_mac_wr,
  output logic [DATA_W-1:0] tx_mac_data,
  output logic [BE_W-1:0]   tx_mac_be,
  output logic              tx_mac_sop,
  output logic              tx_mac_eop,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frames_sent,
  output logic [31:0]       bytes_sent
);
  localparam int NB = DATA_W / 8;
  localparam int GC_W = IFG_CYC > 1 ? $clog2(IFG_CYC) : 1;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] RANGE = 32'(MAX_LEN - MIN_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, FIN} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, words_q, words_d, widx_q, widx_d;
  logic [31:0]        lfsr_len_q, lfsr_len_d, lfsr_pat_q, lfsr_pat_d, fidx_q, fidx_d;
  logic               first_q, first_d, stop_q, stop_d;
  logic [GC_W-1:0]    gap_q, gap_d;
  logic               wr_q, wr_d, sop_q, sop_d, eop_q, eop_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [31:0]        frames_q, frames_d, bytes_q, bytes_d;

  logic [31:0]        raw_len, len_clamp;
  logic [LEN_W-1:0]   len_n, words_n, cur_len, cur_words;
  logic [DATA_W-1:0]  word, pat1;
  logic [31:0]        bk;
  logic [7:0]         bv;
  logic               last, emit;
  logic [32:0]        bsum;

  // Frame length for the next frame (clamped) and the length/word count of the frame being emitted.
  always_comb begin
    raw_len   = len_mode == 2'd2 ? 32'(MIN_LEN) + lfsr_len_q % RANGE :
                (len_mode == 2'd1 && !first_q) ? (32'(len_q) >= 32'(MAX_LEN) ? 32'(MIN_LEN) : 32'(len_q) + 32'd1) :
                32'(fix_len);
    len_clamp = raw_len < 32'(MIN_LEN) ? 32'(MIN_LEN) : raw_len > 32'(MAX_LEN) ? 32'(MAX_LEN) : raw_len;
    len_n     = LEN_W'(len_clamp);
    words_n   = LEN_W'((len_clamp + 32'(NB - 1)) / 32'(NB));
    cur_len   = state_q == LOAD ? len_n : len_q;
    cur_words = state_q == LOAD ? words_n : words_q;
  end

  // Payload word builder: byte 0 in the MSBs, bytes past the frame end forced to zero.
  always_comb begin
    pat1 = '0;
    word = '0;
    bk   = '0;
    bv   = '0;
    for (int i = 0; i < DATA_W; i++) pat1[DATA_W-1-i] = lfsr_pat_q[31 - (i % 32)];
    for (int j = 0; j < NB; j++) begin
      bk = 32'(widx_q) * 32'(NB) + 32'(j);
      bv = pat_sel ? pat1[DATA_W-1-8*j -: 8] : fidx_q[7:0] + bk[7:0];
`ifdef PKT_GEN_SEQ_EN
      bv = bk < 32'd4 ? 8'(fidx_q >> (5'd24 - {bk[1:0], 3'b000})) : bv;
`endif
      bv = bk >= 32'(cur_len) ? 8'h00 : bv;
      word[DATA_W-1-8*j -: 8] = bv;
    end
    last = LEN_W'(widx_q + 1'b1) == cur_words;
    emit = tx_mac_wa && (state_q == LOAD || state_q == SEND);
    bsum = 33'(bytes_q) + 33'(cur_len);
  end

  // Next-state, word emission and statistics.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    words_d    = words_q;
    widx_d     = widx_q;
    lfsr_len_d = lfsr_len_q;
    lfsr_pat_d = lfsr_pat_q;
    fidx_d     = fidx_q;
    first_d    = first_q;
    stop_d     = stop_q | stop;
    gap_d      = gap_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    be_d       = be_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    frames_d   = frames_q;
    bytes_d    = bytes_q;
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          state_d  = LOAD;
          first_d  = 1'b1;
          fidx_d   = '0;
          frames_d = '0;
          bytes_d  = '0;
        end
      end
      LOAD: begin
        state_d    = SEND;
        len_d      = len_n;
        words_d    = words_n;
        widx_d     = '0;
        first_d    = 1'b0;
        lfsr_len_d = lfsr_step(lfsr_len_q);
      end
      SEND: ;
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GC_W'(IFG_CYC - 1))
          state_d = (stop_q || stop || (frame_cnt != 16'd0 && frames_q == {16'h0, frame_cnt})) ? FIN : LOAD;
      end
      FIN: begin
        state_d = IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      wr_d       = 1'b1;
      data_d     = word;
      sop_d      = widx_q == '0;
      eop_d      = last;
      be_d       = last ? BE_W'(cur_len % LEN_W'(NB)) : '0;
      lfsr_pat_d = pat_sel ? lfsr_step(lfsr_pat_q) : lfsr_pat_q;
      widx_d     = last ? '0 : LEN_W'(widx_q + 1'b1);
      if (last) begin
        state_d  = GAP;
        gap_d    = '0;
        fidx_d   = fidx_q + 32'd1;
        frames_d = &frames_q ? frames_q : frames_q + 32'd1;
        bytes_d  = bsum[32] ? '1 : bsum[31:0];
      end
    end
    busy_d = state_d == LOAD || state_d == SEND || state_d == GAP;
    done_d = state_d == FIN;
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= LEN_W'(MIN_LEN);
      words_q    <= '0;
      widx_q     <= '0;
      lfsr_len_q <= SEED;
      lfsr_pat_q <= SEED;
      fidx_q     <= '0;
      first_q    <= 1'b0;
      stop_q     <= 1'b0;
      gap_q      <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      be_q       <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frames_q   <= '0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      words_q    <= words_d;
      widx_q     <= widx_d;
      lfsr_len_q <= lfsr_len_d;
      lfsr_pat_q <= lfsr_pat_d;
      fidx_q     <= fidx_d;
      first_q    <= first_d;
      stop_q     <= stop_d;
      gap_q      <= gap_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      frames_q   <= frames_d;
      bytes_q    <= bytes_d;
    end
  end

  assign tx_mac_wr   = wr_q;
  assign tx_mac_data = data_q;
  assign tx_mac_be   = be_q;
  assign tx_mac_sop  = sop_q;
  assign tx_mac_eop  = eop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frames_sent = frames_q;
  assign bytes_sent  = bytes_q;
endmodule
